// File: rtl/code_loader.sv
// Byte-serial loader for the 256x16 code memory: COUNT, then HI/LO pairs, CPU held while loading.
// Optional trailing zero-sum checksum byte when CODE_LOADER_CHECKSUM_EN is defined.
module code_loader #(
    parameter logic [7:0]  START_ADDR     = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_mem_address,
    output logic [15:0] o_mem_data,
    output logic        o_mem_we,
    output logic        o_cpu_halt,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE,
`ifdef CODE_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_FINISH
    } state_t;

    state_t         r_state, w_next;
    logic [7:0]     r_count, r_idx, r_hi, r_addr;
    logic [15:0]    r_data;
    logic           r_error;
    logic [TW-1:0]  r_tmo;
    logic           w_rx_state, w_xfer, w_tmo_hit, w_last, w_chk_bad;

`ifdef CODE_LOADER_CHECKSUM_EN
    logic [7:0]     r_sum;
    assign w_rx_state = (r_state == S_COUNT) || (r_state == S_HI) ||
                        (r_state == S_LO) || (r_state == S_CHECK);
    assign w_chk_bad  = (r_state == S_CHECK) && w_xfer && (8'(r_sum + i_rx_data) != 8'h00);
`else
    assign w_rx_state = (r_state == S_COUNT) || (r_state == S_HI) || (r_state == S_LO);
    assign w_chk_bad  = 1'b0;
`endif

    assign w_xfer    = i_rx_valid && w_rx_state;
    assign w_tmo_hit = w_rx_state && !w_xfer && (r_tmo == TMO_LAST);
    // COUNT of 0 means 256 words: 0 - 1 wraps to index 8'hFF
    assign w_last    = (r_idx == 8'(r_count - 8'd1));

    assign o_rx_ready    = w_rx_state;
    assign o_mem_we      = (r_state == S_WRITE);
    assign o_done        = (r_state == S_FINISH);
    assign o_busy        = (r_state != S_IDLE);
    assign o_cpu_halt    = (r_state != S_IDLE);
    assign o_error       = r_error;
    assign o_mem_address = r_addr;
    assign o_mem_data    = r_data;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_load) w_next = S_COUNT;
            S_COUNT:  if (w_xfer) w_next = S_HI;
            S_HI:     if (w_xfer) w_next = S_LO;
            S_LO:     if (w_xfer) w_next = S_WRITE;
`ifdef CODE_LOADER_CHECKSUM_EN
            S_WRITE:  w_next = w_last ? S_CHECK : S_HI;
            S_CHECK:  if (w_xfer) w_next = w_chk_bad ? S_IDLE : S_FINISH;
`else
            S_WRITE:  w_next = w_last ? S_FINISH : S_HI;
`endif
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_tmo_hit) w_next = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_idx   <= '0;
            r_hi    <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_error <= 1'b0;
            r_tmo   <= '0;
        end else begin
            if (r_state == S_IDLE && i_load) begin
                r_idx   <= '0;
                r_error <= 1'b0;
            end
            if (w_tmo_hit || w_chk_bad) r_error <= 1'b1;
            if (w_xfer && r_state == S_COUNT) r_count <= i_rx_data;
            if (w_xfer && r_state == S_HI)    r_hi    <= i_rx_data;
            // address/data change only on entry to WRITE so they hold between writes
            if (w_xfer && r_state == S_LO) begin
                r_data <= {r_hi, i_rx_data};
                r_addr <= 8'(START_ADDR + r_idx);
            end
            if (r_state == S_WRITE) r_idx <= r_idx + 8'd1;
            if (!w_rx_state || w_xfer || w_tmo_hit) r_tmo <= '0;
            else                                    r_tmo <= r_tmo + 1'b1;
        end
    end

`ifdef CODE_LOADER_CHECKSUM_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                          r_sum <= '0;
        else if (r_state == S_IDLE && i_load)  r_sum <= '0;
        else if (w_xfer)                       r_sum <= 8'(r_sum + i_rx_data);
    end
`endif

endmodule

// File: tb/tb_code_loader.sv
// Directed bench for code_loader: two instances (start 00 and FE) share one stimulus stream.
module tb_code_loader;
    logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0, rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        a_rdy, a_we, a_halt, a_busy, a_done, a_err;
    logic        b_rdy, b_we, b_halt, b_busy, b_done, b_err;
    logic [7:0]  a_addr, b_addr;
    logic [15:0] a_data, b_data;

    always #5 clk = ~clk;

    code_loader #(.START_ADDR(8'h00), .TIMEOUT_CYCLES(16)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_rx_ready(a_rdy), .o_mem_address(a_addr), .o_mem_data(a_data), .o_mem_we(a_we),
        .o_cpu_halt(a_halt), .o_busy(a_busy), .o_done(a_done), .o_error(a_err));

    code_loader #(.START_ADDR(8'hFE), .TIMEOUT_CYCLES(16)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_rx_ready(b_rdy), .o_mem_address(b_addr), .o_mem_data(b_data), .o_mem_we(b_we),
        .o_cpu_halt(b_halt), .o_busy(b_busy), .o_done(b_done), .o_error(b_err));

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic [15:0] wr [256];
    int cyc = 0, we_a = 0, we_b = 0, done_a = 0, done_b = 0, done_cyc = 0;
    int total = 0, bad = 0, load_cyc = 0;
    int we0, d0, wb0, errs;
    logic [7:0] sum;
    logic hold_load = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_we) begin mem_a[a_addr] <= a_data; we_a <= we_a + 1; end
        if (b_we) begin mem_b[b_addr] <= b_data; we_b <= we_b + 1; end
        if (a_done) begin done_a <= done_a + 1; done_cyc <= cyc; end
        if (b_done) done_b <= done_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic start();
        sum = 8'h00;
        load = 1'b1;
        load_cyc = cyc;
        tick();
        load = hold_load;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin rx_valid = 1'b0; tick(gap); end
        rx_valid = 1'b1;
        rx_data = b;
        n = 0;
        while (!a_rdy && n < 64) begin tick(); n++; end
        chk("rdy_wait", (n < 64), 1);
        tick();
        sum = 8'(sum + b);
    endtask

    task automatic stream(input logic [7:0] cnt, input int gap);
        int nw;
        nw = (cnt == 8'd0) ? 256 : int'(cnt);
        send(cnt, gap);
        for (int i = 0; i < nw; i++) begin
            send(wr[i][15:8], gap);
            send(wr[i][7:0], gap);
        end
`ifdef CODE_LOADER_CHECKSUM_EN
        send(8'(-sum), gap);
`endif
        rx_valid = 1'b0;
        load = 1'b0;
        tick(2);
    endtask

    task automatic snap();
        we0 = we_a; d0 = done_a; wb0 = we_b;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mem_a[i] = 16'h0; mem_b[i] = 16'h0; end
        tick(2);
        chk("rst_rdy", a_rdy, 0);
        chk("rst_we", a_we, 0);
        chk("rst_halt", a_halt, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_err", a_err, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_data", a_data, 0);
        rst_n = 1'b1;
        tick(2);

        // two-word load, RX_VALID held high
        wr[0] = 16'h1234; wr[1] = 16'hABCD;
        snap();
        start();
        chk("ld_halt", a_halt, 1);
        chk("ld_busy", a_busy, 1);
        stream(8'd2, 0);
        chk("w2_mem0", mem_a[0], 16'h1234);
        chk("w2_mem1", mem_a[1], 16'hABCD);
        chk("w2_we", we_a - we0, 2);
        chk("w2_done", done_a - d0, 1);
        chk("w2_halt", a_halt, 0);
        chk("w2_busy", a_busy, 0);
        chk("w2_err", a_err, 0);
        chk("w2_hold_addr", a_addr, 8'h01);
        chk("w2_hold_data", a_data, 16'hABCD);
`ifdef CODE_LOADER_CHECKSUM_EN
        chk("w2_time", done_cyc - load_cyc, 9);
`else
        chk("w2_time", done_cyc - load_cyc, 8);
`endif
        chk("w2b_fe", mem_b[8'hFE], 16'h1234);
        chk("w2b_ff", mem_b[8'hFF], 16'hABCD);

        // asynchronous reset in LO state
        start();
        send(8'h02, 0);
        send(8'h12, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_rdy", a_rdy, 0);
        chk("arst_halt", a_halt, 0);
        chk("arst_busy", a_busy, 0);
        chk("arst_addr", a_addr, 0);
        chk("arst_data", a_data, 0);
        rx_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_idle_rdy", a_rdy, 0);
        chk("arst_idle_busy", a_busy, 0);

        // address wrap on the FE instance
        wr[0] = 16'h1111; wr[1] = 16'h2222; wr[2] = 16'h3333;
        snap();
        start();
        stream(8'd3, 0);
        chk("wrap_fe", mem_b[8'hFE], 16'h1111);
        chk("wrap_ff", mem_b[8'hFF], 16'h2222);
        chk("wrap_00", mem_b[8'h00], 16'h3333);
        chk("wrap_we", we_b - wb0, 3);

        // COUNT=0 loads 256 words
        for (int i = 0; i < 256; i++) wr[i] = {8'(i), 8'(i) ^ 8'hA5};
        snap();
        start();
        stream(8'd0, 0);
        chk("n0_we", we_a - we0, 256);
        chk("n0_done", done_a - d0, 1);
`ifdef CODE_LOADER_CHECKSUM_EN
        chk("n0_time", done_cyc - load_cyc, 771);
`else
        chk("n0_time", done_cyc - load_cyc, 770);
`endif
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem_a[i] !== {8'(i), 8'(i) ^ 8'hA5}) errs++;
            if (mem_b[8'(i + 254)] !== {8'(i), 8'(i) ^ 8'hA5}) errs++;
        end
        chk("n0_mem", errs, 0);

        // stalled stream with LOAD held high throughout (ignored while busy)
        wr[0] = 16'hCAFE; wr[1] = 16'hBEEF; wr[2] = 16'h0102;
        snap();
        hold_load = 1'b1;
        start();
        stream(8'd3, 2);
        hold_load = 1'b0;
        chk("stall_m0", mem_a[0], 16'hCAFE);
        chk("stall_m1", mem_a[1], 16'hBEEF);
        chk("stall_m2", mem_a[2], 16'h0102);
        chk("stall_we", we_a - we0, 3);
        chk("stall_done", done_a - d0, 1);
        chk("stall_busy", a_busy, 0);

        // timeout after HI byte
        snap();
        start();
        send(8'h01, 0);
        send(8'h77, 0);
        rx_valid = 1'b0;
        tick(15);
        chk("tmo_pre_busy", a_busy, 1);
        chk("tmo_pre_err", a_err, 0);
        tick();
        chk("tmo_err", a_err, 1);
        chk("tmo_halt", a_halt, 0);
        chk("tmo_busy", a_busy, 0);
        chk("tmo_done", done_a - d0, 0);
        chk("tmo_we", we_a - we0, 0);
        wr[0] = 16'h5A5B;
        start();
        chk("tmo_clr_err", a_err, 0);
        chk("tmo_clr_busy", a_busy, 1);
        stream(8'd1, 0);
        chk("tmo_reload_mem", mem_a[0], 16'h5A5B);
        chk("tmo_reload_done", done_a - d0, 1);

`ifdef CODE_LOADER_CHECKSUM_EN
        // bad checksum then good checksum
        snap();
        start();
        send(8'h01, 0); send(8'h00, 0); send(8'h01, 0); send(8'h00, 0);
        rx_valid = 1'b0;
        tick(2);
        chk("cks_bad_err", a_err, 1);
        chk("cks_bad_done", done_a - d0, 0);
        chk("cks_bad_busy", a_busy, 0);
        chk("cks_bad_mem", mem_a[0], 16'h0001);
        start();
        send(8'h01, 0); send(8'h00, 0); send(8'h01, 0); send(8'hFE, 0);
        rx_valid = 1'b0;
        tick(2);
        chk("cks_ok_err", a_err, 0);
        chk("cks_ok_done", done_a - d0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
